// File: rtl/gpr_access_arbiter.sv
// Round-robin arbiter sharing the 8x12 register file between the execute unit (0)
// and the debug/loader port (1); sequences one strobe plus a fixed settle wait per access.
module gpr_access_arbiter #(
  parameter int WAIT_CYC = 2
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iREQ0,
  input  logic        iREQ1,
  input  logic        iWE0,
  input  logic        iWE1,
  input  logic [2:0]  iRA00,
  input  logic [2:0]  iRA01,
  input  logic [2:0]  iRA10,
  input  logic [2:0]  iRA11,
  input  logic [2:0]  iWA0,
  input  logic [2:0]  iWA1,
  input  logic [11:0] iWD0,
  input  logic [11:0] iWD1,
  output logic        oACK0,
  output logic        oACK1,
  output logic [11:0] oRD00,
  output logic [11:0] oRD01,
  output logic [11:0] oRD10,
  output logic [11:0] oRD11,
  output logic        oGPR_RD_EN,
  output logic [2:0]  oGPR_RDREG0,
  output logic [2:0]  oGPR_RDREG1,
  output logic        oGPR_WR_EN,
  output logic [2:0]  oGPR_WRREG,
  output logic [11:0] oGPR_DATA,
  input  logic [11:0] iGPR_DATA0,
  input  logic [11:0] iGPR_DATA1,
  output logic        oBUSY
);

  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        state, state_n;
  logic          gnt, gnt_n;
  logic          is_wr, is_wr_n;
  logic          rr_ptr, rr_ptr_n;
  logic [CW-1:0] cnt, cnt_n;

  logic        ack0_n, ack1_n, rd_en_n, wr_en_n, busy_n;
  logic [11:0] rd00_n, rd01_n, rd10_n, rd11_n, data_n;
  logic [2:0]  rdreg0_n, rdreg1_n, wrreg_n;
  logic        g, we_g, req_g;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= S_IDLE;
      gnt         <= 1'b0;
      is_wr       <= 1'b0;
      rr_ptr      <= 1'b0;
      cnt         <= '0;
      oACK0       <= 1'b0;
      oACK1       <= 1'b0;
      oRD00       <= '0;
      oRD01       <= '0;
      oRD10       <= '0;
      oRD11       <= '0;
      oGPR_RD_EN  <= 1'b0;
      oGPR_WR_EN  <= 1'b0;
      oGPR_RDREG0 <= '0;
      oGPR_RDREG1 <= '0;
      oGPR_WRREG  <= '0;
      oGPR_DATA   <= '0;
      oBUSY       <= 1'b0;
    end else begin
      state       <= state_n;
      gnt         <= gnt_n;
      is_wr       <= is_wr_n;
      rr_ptr      <= rr_ptr_n;
      cnt         <= cnt_n;
      oACK0       <= ack0_n;
      oACK1       <= ack1_n;
      oRD00       <= rd00_n;
      oRD01       <= rd01_n;
      oRD10       <= rd10_n;
      oRD11       <= rd11_n;
      oGPR_RD_EN  <= rd_en_n;
      oGPR_WR_EN  <= wr_en_n;
      oGPR_RDREG0 <= rdreg0_n;
      oGPR_RDREG1 <= rdreg1_n;
      oGPR_WRREG  <= wrreg_n;
      oGPR_DATA   <= data_n;
      oBUSY       <= busy_n;
    end
  end

  // File address/data are only reloaded at grant, so both strobe edges see identical operands.
  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    is_wr_n  = is_wr;
    rr_ptr_n = rr_ptr;
    cnt_n    = cnt;
    ack0_n   = oACK0;
    ack1_n   = oACK1;
    rd00_n   = oRD00;
    rd01_n   = oRD01;
    rd10_n   = oRD10;
    rd11_n   = oRD11;
    rdreg0_n = oGPR_RDREG0;
    rdreg1_n = oGPR_RDREG1;
    wrreg_n  = oGPR_WRREG;
    data_n   = oGPR_DATA;
    rd_en_n  = 1'b0;
    wr_en_n  = 1'b0;
    g        = (iREQ0 && iREQ1) ? rr_ptr : iREQ1;
    we_g     = g ? iWE1 : iWE0;
    req_g    = gnt ? iREQ1 : iREQ0;

    case (state)
      S_IDLE: begin
        if (iREQ0 || iREQ1) begin
          gnt_n    = g;
          rr_ptr_n = ~g;
          is_wr_n  = we_g;
          if (we_g) begin
            wrreg_n = g ? iWA1 : iWA0;
            data_n  = g ? iWD1 : iWD0;
            wr_en_n = 1'b1;
          end else begin
            rdreg0_n = g ? iRA10 : iRA00;
            rdreg1_n = g ? iRA11 : iRA01;
            rd_en_n  = 1'b1;
          end
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == LAST_WAIT) begin
          if (!is_wr) begin
            if (gnt) begin
              rd10_n = iGPR_DATA0;
              rd11_n = iGPR_DATA1;
            end else begin
              rd00_n = iGPR_DATA0;
              rd01_n = iGPR_DATA1;
            end
          end
          if (gnt) ack1_n = 1'b1;
          else     ack0_n = 1'b1;
          state_n = S_DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (!req_g) begin
          if (gnt) ack1_n = 1'b0;
          else     ack0_n = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_gpr_access_arbiter.sv
// Directed bench for gpr_access_arbiter with a behavioural edge-triggered register file.
module tb_gpr_access_arbiter;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iREQ0, iREQ1, iWE0, iWE1;
  logic [2:0]  iRA00, iRA01, iRA10, iRA11, iWA0, iWA1;
  logic [11:0] iWD0, iWD1;
  logic        oACK0, oACK1;
  logic [11:0] oRD00, oRD01, oRD10, oRD11;
  logic        oGPR_RD_EN, oGPR_WR_EN;
  logic [2:0]  oGPR_RDREG0, oGPR_RDREG1, oGPR_WRREG;
  logic [11:0] oGPR_DATA;
  logic [11:0] iGPR_DATA0 = '0;
  logic [11:0] iGPR_DATA1 = '0;
  logic        oBUSY;

  int checkCount = 0;
  int failCount = 0;
  int rdPulses = 0;
  int wrPulses = 0;
  int edges;

  logic [11:0] fileMem [8];

  gpr_access_arbiter #(.WAIT_CYC(2)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iREQ0(iREQ0), .iREQ1(iREQ1), .iWE0(iWE0), .iWE1(iWE1),
    .iRA00(iRA00), .iRA01(iRA01), .iRA10(iRA10), .iRA11(iRA11),
    .iWA0(iWA0), .iWA1(iWA1), .iWD0(iWD0), .iWD1(iWD1),
    .oACK0(oACK0), .oACK1(oACK1),
    .oRD00(oRD00), .oRD01(oRD01), .oRD10(oRD10), .oRD11(oRD11),
    .oGPR_RD_EN(oGPR_RD_EN), .oGPR_RDREG0(oGPR_RDREG0), .oGPR_RDREG1(oGPR_RDREG1),
    .oGPR_WR_EN(oGPR_WR_EN), .oGPR_WRREG(oGPR_WRREG), .oGPR_DATA(oGPR_DATA),
    .iGPR_DATA0(iGPR_DATA0), .iGPR_DATA1(iGPR_DATA1),
    .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  // Register file model: both strobe edges act, reads settle 3ns later (well inside 2 clocks).
  initial for (int i = 0; i < 8; i++) fileMem[i] = '0;

  always @(posedge oGPR_WR_EN or negedge oGPR_WR_EN)
    fileMem[oGPR_WRREG] = oGPR_DATA;

  always @(posedge oGPR_RD_EN or negedge oGPR_RD_EN) begin
    #3;
    iGPR_DATA0 = fileMem[oGPR_RDREG0];
    iGPR_DATA1 = fileMem[oGPR_RDREG1];
  end

  always @(negedge iCLK) begin
    if (oGPR_RD_EN) rdPulses++;
    if (oGPR_WR_EN) wrPulses++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic applyStimulus(input int k, input logic we, input logic [2:0] ra0,
                               input logic [2:0] ra1, input logic [2:0] wa, input logic [11:0] wd);
    if (k == 0) begin
      iWE0 = we; iRA00 = ra0; iRA01 = ra1; iWA0 = wa; iWD0 = wd; iREQ0 = 1'b1;
    end else begin
      iWE1 = we; iRA10 = ra0; iRA11 = ra1; iWA1 = wa; iWD1 = wd; iREQ1 = 1'b1;
    end
  endtask

  task automatic dropRequest(input int k);
    if (k == 0) iREQ0 = 1'b0;
    else        iREQ1 = 1'b0;
  endtask

  function automatic logic ackOf(input int k);
    return (k == 0) ? oACK0 : oACK1;
  endfunction

  task automatic waitAck(input int k, input string tag, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (ackOf(k)) break;
    end
    if (!ackOf(k)) checkOutput({tag, " ack timeout"}, 32'(ackOf(k)), 32'd1);
  endtask

  task automatic finishReq(input int k, input string tag);
    dropRequest(k);
    tick();
    checkOutput({tag, " ack release"}, 32'(ackOf(k)), 32'd0);
    checkOutput({tag, " idle busy"}, 32'(oBUSY), 32'd0);
  endtask

  task automatic resetDut();
    @(negedge iCLK);
    iRST_N = 1'b0;
    #2;
    iRST_N = 1'b1;
    tick();
  endtask

  initial begin
    iREQ0 = 0; iREQ1 = 0; iWE0 = 0; iWE1 = 0;
    iRA00 = 0; iRA01 = 0; iRA10 = 0; iRA11 = 0;
    iWA0 = 0; iWA1 = 0; iWD0 = 0; iWD1 = 0;

    repeat (2) @(posedge iCLK);
    #1;
    checkOutput("reset busy", 32'(oBUSY), 32'd0);
    checkOutput("reset acks", {30'd0, oACK1, oACK0}, 32'd0);
    checkOutput("reset strobes", {30'd0, oGPR_WR_EN, oGPR_RD_EN}, 32'd0);
    checkOutput("reset file bus", {17'd0, oGPR_RDREG0, oGPR_WRREG, oGPR_DATA}, 32'd0);
    checkOutput("reset rd00", 32'(oRD00), 32'd0);
    iRST_N = 1'b1;
    tick();

    // Single write r3=0x5A5 from requester 0: one strobe, operands held
    rdPulses = 0;
    wrPulses = 0;
    applyStimulus(0, 1'b1, 3'd0, 3'd0, 3'd3, 12'h5A5);
    tick();
    checkOutput("wr issue strobe", 32'(oGPR_WR_EN), 32'd1);
    checkOutput("wr issue busy", 32'(oBUSY), 32'd1);
    checkOutput("wr issue reg", 32'(oGPR_WRREG), 32'd3);
    checkOutput("wr issue data", 32'(oGPR_DATA), 32'h5A5);
    tick();
    checkOutput("wr wait1 strobe", 32'(oGPR_WR_EN), 32'd0);
    checkOutput("wr wait1 data", {17'd0, oGPR_WRREG, oGPR_DATA}, {17'd0, 3'd3, 12'h5A5});
    tick();
    checkOutput("wr wait2 ack", 32'(oACK0), 32'd0);
    checkOutput("wr wait2 data", {17'd0, oGPR_WRREG, oGPR_DATA}, {17'd0, 3'd3, 12'h5A5});
    tick();
    checkOutput("wr done ack", 32'(oACK0), 32'd1);
    checkOutput("wr done data", {17'd0, oGPR_WRREG, oGPR_DATA}, {17'd0, 3'd3, 12'h5A5});
    finishReq(0, "wr");
    checkOutput("wr strobe count", 32'(wrPulses), 32'd1);
    checkOutput("wr no read strobe", 32'(rdPulses), 32'd0);
    checkOutput("wr leaves rd00", 32'(oRD00), 32'd0);

    // Requester 1 reads r3,r0 after the write
    applyStimulus(1, 1'b0, 3'd3, 3'd0, 3'd0, 12'h000);
    waitAck(1, "rd1", edges);
    checkOutput("rd1 latency", 32'(edges), 32'd4);
    checkOutput("rd1 rd10", 32'(oRD10), 32'h5A5);
    checkOutput("rd1 rd11", 32'(oRD11), 32'h000);
    finishReq(1, "rd1");

    // Simultaneous requests: pointer starts at 0, then alternates
    resetDut();
    applyStimulus(0, 1'b0, 3'd3, 3'd3, 3'd0, 12'h000);
    applyStimulus(1, 1'b0, 3'd0, 3'd3, 3'd0, 12'h000);
    repeat (4) tick();
    checkOutput("rr1 acks", {30'd0, oACK1, oACK0}, 32'b01);
    checkOutput("rr1 rd0x", {8'd0, oRD00, oRD01}, {8'd0, 12'h5A5, 12'h5A5});
    dropRequest(0);
    tick();
    checkOutput("rr1 release", {30'd0, oACK1, oACK0}, 32'b00);
    applyStimulus(0, 1'b0, 3'd0, 3'd0, 3'd0, 12'h000);
    repeat (4) tick();
    checkOutput("rr2 acks", {30'd0, oACK1, oACK0}, 32'b10);
    checkOutput("rr2 rd1x", {8'd0, oRD10, oRD11}, {8'd0, 12'h000, 12'h5A5});
    finishReq(1, "rr2");
    waitAck(0, "rr2 tail", edges);
    checkOutput("rr2 tail rd00", 32'(oRD00), 32'h000);
    finishReq(0, "rr2 tail");

    // Requester 0 lingers in DONE while requester 1 waits
    applyStimulus(0, 1'b0, 3'd3, 3'd3, 3'd0, 12'h000);
    tick();
    applyStimulus(1, 1'b0, 3'd3, 3'd0, 3'd0, 12'h000);
    waitAck(0, "hold", edges);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("hold state", {29'd0, oBUSY, oACK1, oACK0}, 32'b101);
    end
    dropRequest(0);
    tick();
    checkOutput("hold release", 32'(oACK0), 32'd0);
    waitAck(1, "hold rd1", edges);
    checkOutput("hold rd1 latency", 32'(edges), 32'd4);
    checkOutput("hold rd10", 32'(oRD10), 32'h5A5);
    finishReq(1, "hold rd1");

    // Reset pulse in the middle of WAIT aborts the access
    applyStimulus(0, 1'b0, 3'd3, 3'd3, 3'd0, 12'h000);
    tick();
    tick();
    #2;
    iRST_N = 1'b0;
    #1;
    checkOutput("abort busy", 32'(oBUSY), 32'd0);
    checkOutput("abort acks", {30'd0, oACK1, oACK0}, 32'd0);
    checkOutput("abort rdreg", {26'd0, oGPR_RDREG0, oGPR_RDREG1}, 32'd0);
    checkOutput("abort rd00", 32'(oRD00), 32'd0);
    dropRequest(0);
    tick();
    iRST_N = 1'b1;
    tick();
    checkOutput("abort no ack", {29'd0, oBUSY, oACK1, oACK0}, 32'd0);
    applyStimulus(0, 1'b0, 3'd3, 3'd7, 3'd0, 12'h000);
    waitAck(0, "post abort", edges);
    checkOutput("post abort rd00", 32'(oRD00), 32'h5A5);
    checkOutput("post abort rd01", 32'(oRD01), 32'h000);
    finishReq(0, "post abort");

    // Write and read of r7 on the same edge: the write goes first
    resetDut();
    applyStimulus(0, 1'b1, 3'd0, 3'd0, 3'd7, 12'hFFF);
    applyStimulus(1, 1'b0, 3'd7, 3'd7, 3'd0, 12'h000);
    waitAck(0, "race wr", edges);
    checkOutput("race wr first", {30'd0, oACK1, oACK0}, 32'b01);
    finishReq(0, "race wr");
    waitAck(1, "race rd", edges);
    checkOutput("race rd10", 32'(oRD10), 32'hFFF);
    checkOutput("race rd11", 32'(oRD11), 32'hFFF);
    finishReq(1, "race rd");

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
